// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 scan controller.
//   state_e     : scan FSM states
//   NPLANES     : number of BCM bit planes per row
//   R/G/B_OFS   : RGB565 field offsets of the plane-0 bit
//   plane_bits  : {R,G,B} bits of an RGB565 pixel for a given plane
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT,
    BLANK,
    LATCH
  } state_e;

  localparam int NPLANES = 5;
  localparam int R_OFS   = 11;
  // Green has 6 bits; plane p uses bit 6+p, so the top 5 are used.
  localparam int G_OFS   = 6;
  localparam int B_OFS   = 0;

  function automatic logic [2:0] plane_bits(input logic [15:0] px, input logic [2:0] p);
    return {px[4'(R_OFS) + 4'(p)], px[4'(G_OFS) + 4'(p)], px[4'(B_OFS) + 4'(p)]};
  endfunction

endpackage

// File: rtl/hub75_scan_bcm_timer.sv
// BCM on-time down-counter.
//   clk_i       : clock
//   rst_ni      : async active-low reset
//   clear_i     : force the count to zero (scan disabled)
//   load_i      : load load_val_i (only honoured at latch time by the caller)
//   load_val_i  : on-time in clock cycles
//   expired_o   : high in the final on-cycle and while the count is zero
module bcm_timer #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted one cycle early so a registered OE goes high exactly when the
  // count reaches zero: a load of N gives N cycles of OE active.
  assign expired_o = (cnt_q <= W'(1));

endmodule

// File: rtl/hub75_scan.sv
// HUB75 scan controller: reads the dual-half framebuffer one column ahead and
// drives a 1/2^ROW_BITS scan panel with 5-plane binary code modulation.
//   sysclk, rst_n      : clock, async active-low reset
//   enable             : run scan; low blanks the panel and returns to IDLE
//   raddr, rclk        : pixram read address / read strobe (data next cycle)
//   rdata1, rdata2     : top-half / bottom-half RGB565 pixel
//   hub_rgb1, hub_rgb2 : {R,G,B} data pins
//   hub_clk, hub_lat   : shift clock, latch strobe
//   hub_oe_n           : output enable, active low
//   hub_addr           : scan row shown
//   frame_start        : pulse in the LATCH cycle of row 0 plane 0
//
// state | meaning
// IDLE  | panel dark, waiting for enable
// SHIFT | shifting COLS columns of (row, plane); previous plane may be on display
// WAIT  | shift done, waiting for the displayed plane's on-time to expire
// BLANK | panel dark, hub_addr takes the shifted row
// LATCH | hub_lat high, on-timer loads, row/plane advance
module hub75_scan
  import hub75_pkg::*;
#(
  parameter int COLS     = 128,
  parameter int ROW_BITS = 5,
  parameter int BASE_ON  = 64
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic                enable,
  output logic [11:0]         raddr,
  output logic                rclk,
  input  logic [15:0]         rdata1,
  input  logic [15:0]         rdata2,
  output logic [2:0]          hub_rgb1,
  output logic [2:0]          hub_rgb2,
  output logic                hub_clk,
  output logic                hub_lat,
  output logic                hub_oe_n,
  output logic [ROW_BITS-1:0] hub_addr,
  output logic                frame_start
);

  localparam int TW      = $clog2(BASE_ON * 16) + 1;
  localparam int SC_W    = $clog2(2 * COLS + 2);
  localparam int SC_LAST = 2 * COLS + 1;

  state_e              state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [2:0]          plane_q, plane_d;
  logic [SC_W-1:0]     sc_q, sc_d;
  logic [11:0]         raddr_q, raddr_d;
  logic                rclk_q, rclk_d;
  logic [2:0]          rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic                hclk_q, hclk_d;
  logic                lat_q, lat_d;
  logic                oe_n_q, oe_n_d;
  logic [ROW_BITS-1:0] haddr_q, haddr_d;
  logic                fs_q, fs_d;

  logic                tmr_clear, tmr_load, tmr_expired;
  logic [TW-1:0]       tmr_val;
  logic [SC_W-1:0]     col_idx;

  assign tmr_val = TW'(BASE_ON) << plane_q;
  assign col_idx = sc_q >> 1;

  bcm_timer #(.W(TW)) u_timer (
    .clk_i      (sysclk),
    .rst_ni     (rst_n),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // SHIFT cycle sc: even sc<2*COLS issues the read of column sc/2; even
  // 2..2*COLS captures the column read two cycles earlier (clk falls);
  // odd 3..2*COLS+1 raises hub_clk.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    plane_d   = plane_q;
    sc_d      = sc_q;
    raddr_d   = raddr_q;
    rclk_d    = 1'b0;
    rgb1_d    = rgb1_q;
    rgb2_d    = rgb2_q;
    hclk_d    = 1'b0;
    lat_d     = 1'b0;
    oe_n_d    = tmr_expired;
    haddr_d   = haddr_q;
    fs_d      = 1'b0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    if (!enable) begin
      state_d   = IDLE;
      row_d     = '0;
      plane_d   = '0;
      sc_d      = '0;
      oe_n_d    = 1'b1;
      tmr_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          sc_d    = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          sc_d = sc_q + SC_W'(1);
          if (!sc_q[0] && sc_q < SC_W'(2 * COLS)) begin
            rclk_d  = 1'b1;
            raddr_d = 12'(int'(row_q) * COLS + int'(col_idx));
          end
          if (!sc_q[0] && sc_q >= SC_W'(2) && sc_q <= SC_W'(2 * COLS)) begin
            rgb1_d = plane_bits(rdata1, plane_q);
            rgb2_d = plane_bits(rdata2, plane_q);
          end
          if (sc_q[0] && sc_q >= SC_W'(3)) begin
            hclk_d = 1'b1;
          end
          if (sc_q == SC_W'(SC_LAST)) begin
            sc_d    = '0;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (tmr_expired) begin
            haddr_d = row_q;
            state_d = BLANK;
          end
        end
        BLANK: begin
          lat_d   = 1'b1;
          fs_d    = (row_q == '0) && (plane_q == '0);
          state_d = LATCH;
        end
        LATCH: begin
          tmr_load = 1'b1;
          oe_n_d   = 1'b0;
          state_d  = SHIFT;
          if (plane_q == 3'(NPLANES - 1)) begin
            plane_d = '0;
            row_d   = row_q + ROW_BITS'(1);
          end else begin
            plane_d = plane_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      plane_q <= '0;
      sc_q    <= '0;
      raddr_q <= '0;
      rclk_q  <= 1'b0;
      rgb1_q  <= '0;
      rgb2_q  <= '0;
      hclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      haddr_q <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      sc_q    <= sc_d;
      raddr_q <= raddr_d;
      rclk_q  <= rclk_d;
      rgb1_q  <= rgb1_d;
      rgb2_q  <= rgb2_d;
      hclk_q  <= hclk_d;
      lat_q   <= lat_d;
      oe_n_q  <= oe_n_d;
      haddr_q <= haddr_d;
      fs_q    <= fs_d;
    end
  end

  assign raddr       = raddr_q;
  assign rclk        = rclk_q;
  assign hub_rgb1    = rgb1_q;
  assign hub_rgb2    = rgb2_q;
  assign hub_clk     = hclk_q;
  assign hub_lat     = lat_q;
  assign hub_oe_n    = oe_n_q;
  assign hub_addr    = haddr_q;
  assign frame_start = fs_q;

endmodule
